// File: rtl/lcplc_input_framer_if.sv
// Raw-sample and framed-sample stream bundle for the LCPLC input framer.
// The framer drives through `master`; the neighbouring source and coder use `slave`.
interface lcplc_input_framer_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  input_valid;
  logic                  input_ready;
  logic [DATA_WIDTH-1:0] input_data;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_last_r;
  logic                  x_last_s;
  logic                  x_last_b;
  logic                  x_last_i;

  modport master (
    input  input_valid, input_data, x_ready,
    output input_ready, x_valid, x_data, x_last_r, x_last_s, x_last_b, x_last_i
  );

  modport slave (
    output input_valid, input_data, x_ready,
    input  input_ready, x_valid, x_data, x_last_r, x_last_s, x_last_b, x_last_i
  );
endinterface

// File: rtl/lcplc_input_framer.sv
// Frames a slice/band/row-ordered sample stream with last_r/s/b/i flags for the LCPLC coder.
// Optional input_last consistency checker is enabled by defining LCPLC_FRAMER_CHECK_EN.
module lcplc_input_framer #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DIM_WIDTH       = 4,
  parameter int unsigned BAND_WIDTH      = 10,
  parameter int unsigned SLICE_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIM_WIDTH-1:0]       cfg_cols_m1,
  input  logic [DIM_WIDTH-1:0]       cfg_rows_m1,
  input  logic [BAND_WIDTH-1:0]      cfg_bands_m1,
  input  logic [SLICE_CNT_WIDTH-1:0] cfg_slices_m1,
  output logic                       busy,
`ifdef LCPLC_FRAMER_CHECK_EN
  input  logic                       input_last,
  output logic                       frame_error,
  output logic [15:0]                frame_error_count,
`endif
  lcplc_input_framer_if.master       bus
);

  localparam int unsigned BeatW = DATA_WIDTH + 4;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                     r_state, w_state_next;
  logic [DIM_WIDTH-1:0]       r_cols_m1, r_rows_m1;
  logic [BAND_WIDTH-1:0]      r_bands_m1;
  logic [SLICE_CNT_WIDTH-1:0] r_slices_m1;
  logic [DIM_WIDTH-1:0]       r_col, r_row, w_col_next, w_row_next;
  logic [BAND_WIDTH-1:0]      r_band, w_band_next;
  logic [SLICE_CNT_WIDTH-1:0] r_slice, w_slice_next;

  logic                       r_main_valid, w_main_valid_next;
  logic                       r_skid_valid, w_skid_valid_next;
  logic [BeatW-1:0]           r_main, w_main_next;
  logic [BeatW-1:0]           r_skid, w_skid_next;
  logic                       r_in_ready;

  logic [DIM_WIDTH-1:0]       w_cols_m1, w_rows_m1;
  logic [BAND_WIDTH-1:0]      w_bands_m1;
  logic [SLICE_CNT_WIDTH-1:0] w_slices_m1;
  logic                       w_last_r, w_last_s, w_last_b, w_last_i;
  logic                       w_in_fire, w_out_fire;
  logic [BeatW-1:0]           w_beat;

  assign w_in_fire  = bus.input_valid & r_in_ready;
  assign w_out_fire = r_main_valid & bus.x_ready;

  // In IDLE the live cfg frames the first sample; the shadow copy is loaded on that same edge.
  assign w_cols_m1   = (r_state == StIdle) ? cfg_cols_m1   : r_cols_m1;
  assign w_rows_m1   = (r_state == StIdle) ? cfg_rows_m1   : r_rows_m1;
  assign w_bands_m1  = (r_state == StIdle) ? cfg_bands_m1  : r_bands_m1;
  assign w_slices_m1 = (r_state == StIdle) ? cfg_slices_m1 : r_slices_m1;

  assign w_last_r = (r_col == w_cols_m1);
  assign w_last_s = w_last_r & (r_row == w_rows_m1);
  assign w_last_b = w_last_s & (r_band == w_bands_m1);
  assign w_last_i = w_last_b & (r_slice == w_slices_m1);

  assign w_beat = {bus.input_data, w_last_r, w_last_s, w_last_b, w_last_i};

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_band_next  = r_band;
    w_slice_next = r_slice;
    if (w_in_fire) begin
      if (w_last_i) begin
        w_state_next = StIdle;
        w_col_next   = '0;
        w_row_next   = '0;
        w_band_next  = '0;
        w_slice_next = '0;
      end else begin
        w_state_next = StRun;
        if (w_last_b) begin
          w_col_next   = '0;
          w_row_next   = '0;
          w_band_next  = '0;
          w_slice_next = r_slice + SLICE_CNT_WIDTH'(1);
        end else if (w_last_s) begin
          w_col_next  = '0;
          w_row_next  = '0;
          w_band_next = r_band + BAND_WIDTH'(1);
        end else if (w_last_r) begin
          w_col_next = '0;
          w_row_next = r_row + DIM_WIDTH'(1);
        end else begin
          w_col_next = r_col + DIM_WIDTH'(1);
        end
      end
    end
  end

  // Skid buffer: input_ready is low only while the skid entry is occupied, so no
  // accept can coincide with a full skid.
  always_comb begin
    w_main_valid_next = r_main_valid;
    w_main_next       = r_main;
    w_skid_valid_next = r_skid_valid;
    w_skid_next       = r_skid;
    if (r_skid_valid) begin
      if (w_out_fire) begin
        w_main_next       = r_skid;
        w_skid_valid_next = 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_main_valid || w_out_fire) begin
        w_main_valid_next = 1'b1;
        w_main_next       = w_beat;
      end else begin
        w_skid_valid_next = 1'b1;
        w_skid_next       = w_beat;
      end
    end else if (w_out_fire) begin
      w_main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_band       <= '0;
      r_slice      <= '0;
      r_cols_m1    <= '0;
      r_rows_m1    <= '0;
      r_bands_m1   <= '0;
      r_slices_m1  <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_col        <= w_col_next;
      r_row        <= w_row_next;
      r_band       <= w_band_next;
      r_slice      <= w_slice_next;
      r_main_valid <= w_main_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_main       <= w_main_next;
      r_skid       <= w_skid_next;
      r_in_ready   <= ~w_skid_valid_next;
      if ((r_state == StIdle) && w_in_fire) begin
        r_cols_m1   <= cfg_cols_m1;
        r_rows_m1   <= cfg_rows_m1;
        r_bands_m1  <= cfg_bands_m1;
        r_slices_m1 <= cfg_slices_m1;
      end
    end
  end

  assign bus.input_ready = r_in_ready;
  assign bus.x_valid     = r_main_valid;
  assign bus.x_data      = r_main[BeatW-1:4];
  assign bus.x_last_r    = r_main[3];
  assign bus.x_last_s    = r_main[2];
  assign bus.x_last_b    = r_main[1];
  assign bus.x_last_i    = r_main[0];
  assign busy            = (r_state == StRun);

`ifdef LCPLC_FRAMER_CHECK_EN
  logic        r_frame_error;
  logic [15:0] r_frame_error_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_error       <= 1'b0;
      r_frame_error_count <= '0;
    end else if (w_in_fire && (input_last != w_last_i)) begin
      r_frame_error <= 1'b1;
      if (r_frame_error_count != 16'hffff) begin
        r_frame_error_count <= r_frame_error_count + 16'd1;
      end
    end
  end

  assign frame_error       = r_frame_error;
  assign frame_error_count = r_frame_error_count;
`endif

endmodule

// File: tb/tb_lcplc_input_framer.sv
// Self-checking bench for lcplc_input_framer: geometry vector table, hand corner sequences and
// randomized traffic scored against an index-arithmetic reference model.
module tb_lcplc_input_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_cols_m1, cfg_rows_m1;
  logic [9:0]  cfg_bands_m1;
  logic [15:0] cfg_slices_m1;
  logic        busy;

  lcplc_input_framer_if #(.DATA_WIDTH(16)) bus ();

`ifdef LCPLC_FRAMER_CHECK_EN
  logic        input_last;
  logic        frame_error;
  logic [15:0] frame_error_count;
`endif

  lcplc_input_framer #(
    .DATA_WIDTH(16), .DIM_WIDTH(4), .BAND_WIDTH(10), .SLICE_CNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_cols_m1   (cfg_cols_m1),
    .cfg_rows_m1   (cfg_rows_m1),
    .cfg_bands_m1  (cfg_bands_m1),
    .cfg_slices_m1 (cfg_slices_m1),
    .busy          (busy),
`ifdef LCPLC_FRAMER_CHECK_EN
    .input_last       (input_last),
    .frame_error      (frame_error),
    .frame_error_count(frame_error_count),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  f;  // {last_r, last_s, last_b, last_i}
  } beat_t;

  typedef struct {
    int cols, rows, bands, slices, nsamp, mode;
    int er, es, eb, ei;
  } vec_t;

  beat_t  exp_q[$];
  longint m_k, m_c, m_r, m_b, m_s;
  int     n_checks = 0, n_fail = 0;
  int     cnt_r, cnt_s, cnt_b, cnt_i;
  int     cyc = 0;
  int     ovr_idx = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Flags from the sample's position k inside an image of the given (1-based) geometry.
  function automatic logic [3:0] geom(input longint k, input longint c, input longint r,
                                      input longint b, input longint s);
    longint col, row, band, slice;
    logic lr, ls, lb, li;
    col   = k % c;
    row   = (k / c) % r;
    band  = (k / (c * r)) % b;
    slice = k / (c * r * b);
    lr = (col == c - 1);
    ls = lr && (row == r - 1);
    lb = ls && (band == b - 1);
    li = lb && (slice == s - 1);
    return {lr, ls, lb, li};
  endfunction

  function automatic logic [3:0] predict_next();
    if (m_k == 0)
      return geom(0, longint'(cfg_cols_m1) + 1, longint'(cfg_rows_m1) + 1,
                  longint'(cfg_bands_m1) + 1, longint'(cfg_slices_m1) + 1);
    return geom(m_k, m_c, m_r, m_b, m_s);
  endfunction

  task automatic model_accept(input logic [15:0] d);
    beat_t bt;
    if (m_k == 0) begin
      m_c = longint'(cfg_cols_m1) + 1;
      m_r = longint'(cfg_rows_m1) + 1;
      m_b = longint'(cfg_bands_m1) + 1;
      m_s = longint'(cfg_slices_m1) + 1;
    end
    bt.d = d;
    bt.f = geom(m_k, m_c, m_r, m_b, m_s);
    exp_q.push_back(bt);
    m_k = bt.f[0] ? 0 : m_k + 1;
  endtask

  // Called just after a falling edge with inputs driven; returns just after the next one.
  task automatic tick(output bit in_fire);
    bit    out_fire;
    beat_t bt;
`ifdef LCPLC_FRAMER_CHECK_EN
    input_last = (ovr_idx >= 0) ? (m_k == longint'(ovr_idx)) : predict_next()[0];
`endif
    #1;
    check("x_valid", bus.x_valid, exp_q.size() != 0);
    check("input_ready", bus.input_ready, exp_q.size() < 2);
    check("busy", busy, m_k != 0);
    in_fire  = bus.input_valid && bus.input_ready;
    out_fire = bus.x_valid && bus.x_ready;
    if (out_fire && exp_q.size() > 0) begin
      bt = exp_q.pop_front();
      check("x_data", bus.x_data, bt.d);
      check("x_flags", {bus.x_last_r, bus.x_last_s, bus.x_last_b, bus.x_last_i}, bt.f);
      cnt_r += int'(bus.x_last_r);
      cnt_s += int'(bus.x_last_s);
      cnt_b += int'(bus.x_last_b);
      cnt_i += int'(bus.x_last_i);
    end
    if (in_fire) model_accept(bus.input_data);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic ready_for(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input int n, input int mode);
    int sent = 0;
    int guard = 0;
    bit f;
    bus.input_valid = 1'b1;
    bus.input_data  = 16'($urandom);
    while (sent < n && guard < 20 * n + 100) begin
      bus.x_ready = ready_for(mode);
      tick(f);
      if (f) begin
        sent++;
        bus.input_data = 16'($urandom);
      end
      guard++;
    end
    if (sent < n) check("send_timeout", sent, n);
    bus.input_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    bus.input_valid = 1'b0;
    bus.x_ready     = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(f);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_cfg(input int c, input int r, input int b, input int s);
    cfg_cols_m1   = 4'(c);
    cfg_rows_m1   = 4'(r);
    cfg_bands_m1  = 10'(b);
    cfg_slices_m1 = 16'(s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.input_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_k = 0;
    #1;
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_input_ready", bus.input_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_x_data", bus.x_data, 0);
    check("rst_flags", {bus.x_last_r, bus.x_last_s, bus.x_last_b, bus.x_last_i}, 0);
`ifdef LCPLC_FRAMER_CHECK_EN
    check("rst_frame_error", frame_error, 0);
    check("rst_frame_error_count", frame_error_count, 0);
`endif
    @(negedge clk);
    cnt_r = 0; cnt_s = 0; cnt_b = 0; cnt_i = 0;
  endtask

  task automatic check_counts(input string tag, input int er, input int es, input int eb,
                              input int ei);
    check({tag, "_cnt_last_r"}, cnt_r, er);
    check({tag, "_cnt_last_s"}, cnt_s, es);
    check({tag, "_cnt_last_b"}, cnt_b, eb);
    check({tag, "_cnt_last_i"}, cnt_i, ei);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    bit   f;
    vecs[0] = '{3, 1, 2, 1, 48, 0, 12, 6, 2, 1};  // geometry sweep, full rate
    vecs[1] = '{3, 1, 2, 1, 48, 1, 12, 6, 2, 1};  // 1 on / 2 off backpressure
    vecs[2] = '{0, 0, 0, 0,  5, 0,  5, 5, 5, 5};  // every sample is an image
    vecs[3] = '{1, 0, 1, 0,  8, 2,  4, 4, 2, 2};
    vecs[4] = '{0, 2, 0, 1, 12, 1, 12, 4, 4, 2};

    rst = 1'b1;
    bus.input_valid = 1'b0;
    bus.input_data  = '0;
    bus.x_ready     = 1'b0;
`ifdef LCPLC_FRAMER_CHECK_EN
    input_last = 1'b0;
`endif
    set_cfg(0, 0, 0, 0);
    @(negedge clk);

    foreach (vecs[i]) begin
      do_reset();
      set_cfg(vecs[i].cols, vecs[i].rows, vecs[i].bands, vecs[i].slices);
      send(vecs[i].nsamp, vecs[i].mode);
      drain();
      check_counts($sformatf("vec%0d", i), vecs[i].er, vecs[i].es, vecs[i].eb, vecs[i].ei);
    end

    // Mid-image cfg change is ignored; the back-to-back next image picks it up.
    do_reset();
    set_cfg(3, 1, 2, 1);
    send(10, 0);
    cfg_cols_m1 = 4'd1;
    send(38, 0);
    send(24, 0);
    drain();
    check_counts("cfg_capture", 24, 12, 4, 2);

    // Reset with two beats parked in the buffer and the coder stalled.
    do_reset();
    set_cfg(3, 1, 2, 1);
    send(8, 0);
    drain();
    send(2, 3);
    #1;
    check("pre_rst_input_ready", bus.input_ready, 0);
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    do_reset();
    send(48, 0);
    drain();
    check_counts("post_rst", 12, 6, 2, 1);

    // Randomized traffic with cfg changing every cycle.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2));
      bus.input_valid = ($urandom_range(0, 9) < 7);
      bus.input_data  = 16'($urandom);
      bus.x_ready     = ($urandom_range(0, 9) < 6);
      tick(f);
    end
    drain();
`ifdef LCPLC_FRAMER_CHECK_EN
    check("random_frame_error", frame_error, 0);

    // input_last one sample early: both the early and the missing marker are errors.
    do_reset();
    set_cfg(3, 1, 2, 1);
    ovr_idx = 46;
    send(48, 0);
    drain();
    ovr_idx = -1;
    check("chk_frame_error", frame_error, 1);
    check("chk_frame_error_count", frame_error_count, 2);
    check_counts("chk", 12, 6, 2, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
